mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shared single-port memory (2^ADDR_W 32-bit words).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 if_req  input  1  instruction-fetch read request; if_addr  input  32  byte address.
REQ-005 dm_req  input  1  CPU data request; dm_we  input  1  write when high; dm_addr  input  32  byte address; dm_wdata  input  32  store data.
REQ-006 ext_req  input  1  external loader request; ext_we  input  1; ext_addr  input  32; ext_wdata  input  32.
REQ-007 if_ack, dm_ack, ext_ack  output  1 each  one-cycle completion pulse to the owning requester.
REQ-008 rdata  output  32  read data, valid only in the cycle the matching ack is high.
REQ-009 mem_addr  output  ADDR_W  word address = granted addr[ADDR_W+1:2]; mem_we  output  1; mem_wdata  output  32; mem_rdata  input  32  memory read data, registered by the memory one cycle after mem_addr.
REQ-010 cpu_stall  output  1  high whenever if_req or dm_req is high and the corresponding ack is not high in that cycle.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-013 In IDLE the arbiter SHALL select one requester, priority ext > dm > if (fixed mode), and latch owner, we, word address and wdata into registers.
REQ-014 In ACCESS mem_addr/mem_wdata SHALL drive the latched values and mem_we SHALL equal latched we; in all other states mem_we SHALL be 0.
REQ-015 In RESP the owner's ack SHALL pulse high for exactly one cycle and rdata SHALL equal mem_rdata; for writes rdata SHALL be 0.
REQ-016 Latency: req high in IDLE at cycle N -> ack high at cycle N+2; minimum request-to-request spacing 3 cycles.
REQ-017 Requesters hold req and operands stable until ack; changes after grant SHALL be ignored (latched values used).
REQ-018 A req dropped after grant SHALL NOT abort the transaction; ack is still issued.
REQ-019 A req still high in the RESP cycle SHALL NOT be re-granted until the next IDLE evaluation.
REQ-020 Byte address bits [1:0] and bits above ADDR_W+1 SHALL be ignored (wrap modulo memory size).
REQ-021 At most one ack SHALL be high in any cycle; no request SHALL be granted twice for one req assertion.

Reset
REQ-022 reset SHALL force IDLE, all acks 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, busy 0, owner register cleared, round-robin pointer to "dm granted last".
REQ-023 reset asserted mid-transaction (ACCESS or RESP) SHALL abort it with no ack and mem_we 0 from the next cycle.
REQ-024 cpu_stall SHALL remain combinational from req/ack and therefore reflect pending requests during reset.

Configuration
REQ-025 Macro MEM_ARBITER_RR_EN: when defined, if/dm contention with no ext_req SHALL be resolved round-robin (grant the one not granted last, pointer updated on each if/dm grant); ext remains highest priority.
REQ-026 Without MEM_ARBITER_RR_EN, fixed priority ext > dm > if SHALL apply and no pointer register exists.

Verification
REQ-027 Single read: memory word 5 = 0xDEADBEEF, if_req with if_addr 0x14 at cycle 1 -> mem_addr 5 in cycle 2, if_ack and rdata 0xDEADBEEF in cycle 3, cpu_stall high cycles 1-2.
REQ-028 Write: dm_req, dm_we=1, dm_addr 0x08, dm_wdata 0x12345678 -> mem_we=1 with mem_addr 2 one cycle, dm_ack next cycle; later if read of 0x08 returns 0x12345678.
REQ-029 Contention: if_req, dm_req, ext_req together -> ext_ack first, then dm_ack, then if_ack, 3 cycles apart (RR or fixed).
REQ-030 RR: with MEM_ARBITER_RR_EN, if_req and dm_req held continuously for 4 transactions -> ack order if, dm, if, dm; without macro, dm acked every time while dm_req held.
REQ-031 Reset mid-operation: reset asserted in ACCESS cycle of a dm write -> no dm_ack, busy 0 and IDLE next cycle, mem_we 0.
REQ-032 Wrap/alignment: ADDR_W 8, ext write to 0x0000_0403 then if read of 0x0000_0000 -> returns the written value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: 3-requester arbiter for a single-port memory; define MEM_ARBITER_RR_EN for if/dm round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              if_ack,
  output logic              dm_ack,
  output logic              ext_ack,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_stall,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam logic [1:0] O_NONE = 2'd0, O_IF = 2'd1, O_DM = 2'd2, O_EXT = 2'd3;
  logic [1:0]        state, owner, sel;
  logic              we_q, sel_we;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, sel_addr, sel_wdata;
  logic              unused_addr_bits;
`ifdef MEM_ARBITER_RR_EN
  logic last_dm;
  always_comb sel = ext_req ? O_EXT : (dm_req && if_req) ? (last_dm ? O_IF : O_DM) :
                    dm_req ? O_DM : if_req ? O_IF : O_NONE;
  always_ff @(posedge clk)
    if (reset) last_dm <= 1'b1;
    else if (state == IDLE && (sel == O_IF || sel == O_DM)) last_dm <= sel == O_DM;
`else
  always_comb sel = ext_req ? O_EXT : dm_req ? O_DM : if_req ? O_IF : O_NONE;
`endif
  always_comb begin
    sel_we    = sel == O_EXT ? ext_we : sel == O_DM ? dm_we : 1'b0;
    sel_addr  = sel == O_EXT ? ext_addr : sel == O_DM ? dm_addr : if_addr;
    sel_wdata = sel == O_EXT ? ext_wdata : sel == O_DM ? dm_wdata : 32'd0;
  end
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= O_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && sel != O_NONE) begin
      state   <= ACCESS;
      owner   <= sel;
      we_q    <= sel_we;
      addr_q  <= sel_addr[ADDR_W+1:2];
      wdata_q <= sel_wdata;
    end else if (state == ACCESS) begin
      state <= RESP;
    end else if (state == RESP) begin
      state <= IDLE;
    end
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = state == ACCESS && we_q;
  assign if_ack    = state == RESP && owner == O_IF;
  assign dm_ack    = state == RESP && owner == O_DM;
  assign ext_ack   = state == RESP && owner == O_EXT;
  assign rdata     = (state == RESP && !we_q) ? mem_rdata : 32'd0;
  assign busy      = state != IDLE;
  assign cpu_stall = (if_req && !if_ack) || (dm_req && !dm_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 0, dm_req = 0, dm_we = 0, ext_req = 0, ext_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic        if_ack, dm_ack, ext_ack, mem_we, cpu_stall, busy;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem [256];
  int          errors = 0, checks = 0, cyc = 0, t0, te, td, ti, n;
  typedef struct { int id; logic [31:0] d; } exp_t;
  exp_t        q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .if_ack(if_ack), .dm_ack(dm_ack), .ext_ack(ext_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic ackv(input int p);
    return p == 3 ? ext_ack : p == 2 ? dm_ack : if_ack;
  endfunction

  task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 3) begin ext_we = we; ext_addr = a; ext_wdata = d; ext_req = 1; end
    else if (p == 2) begin dm_we = we; dm_addr = a; dm_wdata = d; dm_req = 1; end
    else begin if_addr = a; if_req = 1; end
  endtask

  task automatic wait_ack(input int p, output int t);
    bit got = 0;
    t = -1;
    for (int i = 0; i < 15 && !got; i++) begin
      @(negedge clk);
      if (ackv(p)) begin got = 1; t = cyc; end
    end
    chk($sformatf("ack_arrived_%0d", p), {31'd0, got}, 32'd1);
  endtask

  task automatic drop(input int p);
    if (p == 3) ext_req = 0; else if (p == 2) dm_req = 0; else if_req = 0;
    @(negedge clk);
  endtask

  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    int t;
    drive(p, we, a, d);
    wait_ack(p, t);
    drop(p);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (if_ack || dm_ack || ext_ack) begin
      chk("ack_onehot", int'(if_ack) + int'(dm_ack) + int'(ext_ack), 1);
      if (q.size() == 0) chk("unexpected_ack", {29'd0, ext_ack, dm_ack, if_ack}, 0);
      else begin
        e = q.pop_front();
        chk("ack_owner", ext_ack ? 3 : dm_ack ? 2 : 1, e.id);
        chk("ack_rdata", rdata, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_acks", {29'd0, ext_ack, dm_ack, if_ack}, 0);
    if_req = 1;
    #1 chk("rst_stall", {31'd0, cpu_stall}, 1);
    if_req = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    q.push_back('{3, 32'h0});
    txn(3, 1, 32'h14, 32'hDEADBEEF);
    // single read of word 5 with cycle-exact latency
    q.push_back('{1, 32'hDEADBEEF});
    t0 = cyc;
    drive(1, 0, 32'h14, 0);
    #1 chk("rd_stall_c1", {31'd0, cpu_stall}, 1);
    chk("rd_busy_c1", {31'd0, busy}, 0);
    @(negedge clk);
    chk("rd_mem_addr", {24'd0, mem_addr}, 5);
    chk("rd_mem_we", {31'd0, mem_we}, 0);
    chk("rd_busy_c2", {31'd0, busy}, 1);
    chk("rd_stall_c2", {31'd0, cpu_stall}, 1);
    wait_ack(1, ti);
    chk("rd_latency", ti - t0, 2);
    chk("rd_stall_ack", {31'd0, cpu_stall}, 0);
    drop(1);
    chk("rd_busy_idle", {31'd0, busy}, 0);
    // data write then read-back
    q.push_back('{2, 32'h0});
    drive(2, 1, 32'h08, 32'h12345678);
    @(negedge clk);
    chk("wr_mem_we", {31'd0, mem_we}, 1);
    chk("wr_mem_addr", {24'd0, mem_addr}, 2);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    wait_ack(2, td);
    chk("wr_mem_we_resp", {31'd0, mem_we}, 0);
    drop(2);
    q.push_back('{1, 32'h12345678});
    txn(1, 0, 32'h08, 0);
    // three-way contention
    q.push_back('{3, 32'hDEADBEEF});
    q.push_back('{2, 32'h12345678});
    q.push_back('{1, 32'hDEADBEEF});
    drive(3, 0, 32'h14, 0);
    drive(2, 0, 32'h08, 0);
    drive(1, 0, 32'h14, 0);
    fork
      begin wait_ack(3, te); drop(3); end
      begin wait_ack(2, td); drop(2); end
      begin wait_ack(1, ti); drop(1); end
    join
    chk("cont_ext_dm_gap", td - te, 3);
    chk("cont_dm_if_gap", ti - td, 3);
    // address wrap and byte-offset masking
    q.push_back('{3, 32'h0});
    txn(3, 1, 32'h0000_0403, 32'hCAFEF00D);
    q.push_back('{1, 32'hCAFEF00D});
    drive(1, 0, 32'h0, 0);
    @(negedge clk);
    chk("wrap_mem_addr", {24'd0, mem_addr}, 0);
    wait_ack(1, ti);
    drop(1);
    // reset during ACCESS of a dm write
    drive(2, 1, 32'h0C, 32'hAAAA5555);
    @(negedge clk);
    chk("abort_access_we", {31'd0, mem_we}, 1);
    reset = 1;
    dm_req = 0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_mem_we", {31'd0, mem_we}, 0);
    chk("abort_dm_ack", {31'd0, dm_ack}, 0);
    chk("abort_mem_addr", {24'd0, mem_addr}, 0);
    @(negedge clk);
    chk("abort_dm_ack2", {31'd0, dm_ack}, 0);
    reset = 0;
    @(negedge clk);
    // if and dm held together for four transactions
`ifdef MEM_ARBITER_RR_EN
    q.push_back('{1, 32'hDEADBEEF});
    q.push_back('{2, 32'h12345678});
    q.push_back('{1, 32'hDEADBEEF});
    q.push_back('{2, 32'h12345678});
`else
    repeat (4) q.push_back('{2, 32'h12345678});
`endif
    drive(1, 0, 32'h14, 0);
    drive(2, 0, 32'h08, 0);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (if_ack || dm_ack) n++;
    end
    if_req = 0;
    dm_req = 0;
    chk("held_ack_count", n, 4);
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
